mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-access stage and MEM/WB pipeline register of the 64-bit core. It consumes the EX/MEM register outputs: ALU result or address, store data, destination register index, and the write and memory enables. It performs stores into an internal synchronous data memory, performs loads from it, and registers the result for the register-file write-back port. It also detects misaligned and out-of-range accesses and flags them as faults.

Parameters:
- DATA_W, 64, data path width in bits.
- ADDR_W, 8, word-address width; the memory holds 2**ADDR_W words of DATA_W bits.
- REG_ADDR_W, 5, register index width.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_i, input, 1, synchronous active-high reset.
- stall_i, input, 1, freezes the stage: no memory write, all outputs hold.
- reg_write_en_i, input, 1, the instruction writes a register.
- mem_write_en_i, input, 1, the instruction is a store.
- mem_read_en_i, input, 1, the instruction is a load.
- reg_data1_i, input, DATA_W, ALU result; this is the byte address for loads and stores.
- reg_data2_i, input, DATA_W, store data.
- reg_write_data_i, input, REG_ADDR_W, destination register index.
- reg_write_en_o, output, 1, write-back enable.
- reg_write_data_o, output, REG_ADDR_W, write-back register index.
- wb_data_o, output, DATA_W, write-back data.
- fault_o, output, 1, one-cycle pulse on an illegal memory access.

Behaviour:
- Reset (rst_i=1 at an edge) clears all outputs to 0. Reset has priority over stall_i. Memory contents are not cleared by reset. A store presented in the same cycle as reset is discarded.
- Address decode:
  - widx = reg_data1_i[ADDR_W+2:3].
  - aligned = (reg_data1_i[2:0] == 0).
  - in_range = (reg_data1_i[DATA_W-1:ADDR_W+3] == 0).
  - acc = mem_write_en_i | mem_read_en_i.
  - bad = acc & ~(aligned & in_range).
  - both = mem_write_en_i & mem_read_en_i; this encoding is illegal.
  - fault = bad | both.
- Store: when an edge has rst_i=0, stall_i=0, mem_write_en_i=1 and fault=0, mem[widx] <= reg_data2_i. Any faulting store is suppressed.
- Load: the memory is read synchronously, with one cycle of latency. wb_data_o <= mem[widx] when mem_read_en_i=1, mem_write_en_i=0 and fault=0.
- Non-load: wb_data_o <= reg_data1_i (ALU pass-through). On a faulting access, wb_data_o <= 0.
- reg_write_en_o <= reg_write_en_i & ~fault & (reg_write_data_i != 0). A write to x0 is never forwarded.
- reg_write_data_o <= reg_write_data_i on every non-stalled edge.
- fault_o <= fault on a non-stalled edge. It is 0 on a stalled edge, so each fault is reported exactly once.
- Latency: inputs at edge N appear on the outputs after edge N. Back-to-back instructions are accepted at one per cycle.
- Store then load to the same word on consecutive cycles: the load returns the newly stored value.
- Stall: while stall_i=1, every output and the memory hold. When stall_i drops, the instruction currently on the inputs is processed.
- Address wrap: there is none. Any set upper bit is out of range and causes a fault.
- Memory reads use no asynchronous path. The memory is inferable as block RAM (one write port, one read port).

Test Plan:
1. Store then load: cycle 0 store addr=0x10, data=0xDEADBEEF_CAFEF00D. Cycle 1 load addr=0x10, rd=7 -> cycle 2 shows wb_data_o=0xDEADBEEF_CAFEF00D, reg_write_data_o=7, reg_write_en_o=1, fault_o=0.
2. ALU pass-through: reg_write_en_i=1, no memory flags, reg_data1_i=0x1234, rd=3 -> next cycle wb_data_o=0x1234, reg_write_en_o=1. Same instruction with rd=0 -> reg_write_en_o=0.
3. Misaligned and out-of-range:
   - Store at addr=0x13 -> fault_o=1 for one cycle; a later load from 0x10 returns the old value.
   - Load at addr=0x800 (ADDR_W=8) -> fault_o=1, reg_write_en_o=0, wb_data_o=0.
4. Stall: apply a load, then hold stall_i=1 for 3 cycles with a store to the same word on the inputs -> outputs stay frozen and memory is unchanged. After release, the store commits and fault_o stays 0 throughout.
5. Reset mid-stream: assert rst_i during a store to 0x20 with data 0x55 -> all outputs are 0 after the edge. A later load from 0x20 does not return 0x55. Reset asserted together with stall_i still clears the outputs.
6. Illegal encoding: mem_write_en_i=mem_read_en_i=1 -> fault_o=1, no memory write, reg_write_en_o=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: word-addressed synchronous data
// memory with alignment/range fault detection and a registered write-back port.
module mem_wb_stage #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 8,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  reg_write_en_i,
    input  logic                  mem_write_en_i,
    input  logic                  mem_read_en_i,
    input  logic [DATA_W-1:0]     reg_data1_i,
    input  logic [DATA_W-1:0]     reg_data2_i,
    input  logic [REG_ADDR_W-1:0] reg_write_data_i,
    output logic                  reg_write_en_o,
    output logic [REG_ADDR_W-1:0] reg_write_data_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic                  fault_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic [DATA_W-1:0]     rd_data_r;
    logic [DATA_W-1:0]     alu_data_r;
    logic                  sel_load_r;
    logic                  reg_write_en_r;
    logic [REG_ADDR_W-1:0] reg_write_data_r;
    logic                  fault_r;

    logic [ADDR_W-1:0]     widx_s;
    logic                  aligned_s;
    logic                  in_range_s;
    logic                  acc_s;
    logic                  both_s;
    logic                  fault_s;
    logic                  store_s;
    logic                  load_s;

    // Address decode and access legality.
    always_comb begin
        widx_s     = reg_data1_i[ADDR_W+2:3];
        aligned_s  = (reg_data1_i[2:0] == 3'b000);
        in_range_s = (reg_data1_i[DATA_W-1:ADDR_W+3] == '0);
        acc_s      = mem_write_en_i | mem_read_en_i;
        both_s     = mem_write_en_i & mem_read_en_i;
        fault_s    = (acc_s & ~(aligned_s & in_range_s)) | both_s;
        store_s    = ~rst_i & ~stall_i & mem_write_en_i & ~fault_s;
        load_s     = mem_read_en_i & ~mem_write_en_i & ~fault_s;
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (store_s) begin
            mem_r[widx_s] <= reg_data2_i;
        end
    end

    // Registered read port kept free of reset and muxing so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (!stall_i) begin
            rd_data_r <= mem_r[widx_s];
        end
    end

    // Pipeline register for the write-back controls and the non-load data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_data_r       <= '0;
            sel_load_r       <= 1'b0;
            reg_write_en_r   <= 1'b0;
            reg_write_data_r <= '0;
            fault_r          <= 1'b0;
        end else if (!stall_i) begin
            alu_data_r       <= fault_s ? '0 : reg_data1_i;
            sel_load_r       <= load_s;
            reg_write_en_r   <= reg_write_en_i & ~fault_s & (reg_write_data_i != '0);
            reg_write_data_r <= reg_write_data_i;
            fault_r          <= fault_s;
        end else begin
            // A stalled edge must not repeat a fault report.
            fault_r          <= 1'b0;
        end
    end

    // Output selection between two registered sources.
    always_comb begin
        wb_data_o        = sel_load_r ? rd_data_r : alu_data_r;
        reg_write_en_o   = reg_write_en_r;
        reg_write_data_o = reg_write_data_r;
        fault_o          = fault_r;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed plan steps plus randomized traffic
// compared against an instruction-level reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        rwe = 1'b0;
    logic        mwe = 1'b0;
    logic        mre = 1'b0;
    logic [63:0] d1 = 64'd0;
    logic [63:0] d2 = 64'd0;
    logic [4:0]  rd = 5'd0;
    logic        wen_o;
    logic [4:0]  rd_o;
    logic [63:0] wb_o;
    logic        fault_o;

    int total = 0;
    int bad = 0;

    logic [63:0] mm [256];
    logic        e_wen = 1'b0;
    logic [4:0]  e_rd = 5'd0;
    logic [63:0] e_wb = 64'd0;
    logic        e_f = 1'b0;

    mem_wb_stage dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .reg_write_en_i(rwe), .mem_write_en_i(mwe), .mem_read_en_i(mre),
        .reg_data1_i(d1), .reg_data2_i(d2), .reg_write_data_i(rd),
        .reg_write_en_o(wen_o), .reg_write_data_o(rd_o),
        .wb_data_o(wb_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction per edge: the model decides from the byte address and flags.
    task automatic model();
        logic f;
        if (rst) begin
            e_wen = 1'b0; e_rd = 5'd0; e_wb = 64'd0; e_f = 1'b0;
        end else if (stall) begin
            e_f = 1'b0;
        end else begin
            f = ((mwe || mre) && ((d1 % 64'd8) != 64'd0 || d1 >= 64'd2048)) || (mwe && mre);
            if (f) e_wb = 64'd0;
            else if (mre) e_wb = mm[d1 / 64'd8];
            else e_wb = d1;
            if (mwe && !f) mm[d1 / 64'd8] = d2;
            e_wen = rwe && !f && (rd != 5'd0);
            e_rd  = rd;
            e_f   = f;
        end
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic we_r,
                        input logic w, input logic l, input logic [63:0] a,
                        input logic [63:0] dat, input logic [4:0] dst);
        rst = r; stall = s; rwe = we_r; mwe = w; mre = l; d1 = a; d2 = dat; rd = dst;
        @(posedge clk);
        model();
        #1;
        check({tag, ".fault"}, {63'd0, fault_o}, {63'd0, e_f});
        check({tag, ".wen"}, {63'd0, wen_o}, {63'd0, e_wen});
        check({tag, ".rd"}, {59'd0, rd_o}, {59'd0, e_rd});
        check({tag, ".wb"}, wb_o, e_wb);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] frozen;
        int k;
        // Reset state
        step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        step("rst1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h77, 64'd0, 5'd9);
        check("rst.wb_zero", wb_o, 64'd0);
        // Fill every word so all later loads have a defined value
        for (int i = 0; i < 256; i++)
            step("init", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                 64'(i) * 64'd8, {$urandom, $urandom}, 5'($urandom));

        // 1: store then load on consecutive cycles
        step("t1.st", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h10, 64'hDEADBEEF_CAFEF00D, 5'd0);
        step("t1.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h10, 64'd0, 5'd7);
        check("t1.const", wb_o, 64'hDEADBEEF_CAFEF00D);
        // 2: pass-through and x0
        step("t2.alu", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h1234, 64'd0, 5'd3);
        check("t2.const", wb_o, 64'h1234);
        step("t2.x0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h1234, 64'd0, 5'd0);
        // 3: misaligned store, out-of-range load
        step("t3.mis", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h13, 64'h1111, 5'd0);
        check("t3.pulse", {63'd0, fault_o}, 64'd1);
        step("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        step("t3.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h10, 64'd0, 5'd4);
        check("t3.old", wb_o, 64'hDEADBEEF_CAFEF00D);
        step("t3.oor", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h800, 64'd0, 5'd4);
        // 4: load, then stall with a store to the same word on the inputs
        step("t4.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h18, 64'd0, 5'd5);
        frozen = wb_o;
        for (int i = 0; i < 3; i++) begin
            step("t4.stall", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h18, 64'hABCD, 5'd6);
            check("t4.frozen", wb_o, frozen);
        end
        step("t4.rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h18, 64'hABCD, 5'd6);
        step("t4.ld2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h18, 64'd0, 5'd5);
        check("t4.commit", wb_o, 64'hABCD);
        // 5: reset during a store, reset with stall
        step("t5.rst", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h20, 64'h55, 5'd2);
        step("t5.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h20, 64'd0, 5'd2);
        step("t5.alu", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h99, 64'd0, 5'd8);
        step("t5.rststall", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h99, 64'd0, 5'd8);
        check("t5.cleared", wb_o, 64'd0);
        // 6: both memory enables set
        step("t6.both", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h28, 64'h4242, 5'd1);
        step("t6.ld", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h28, 64'd0, 5'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            k = int'($urandom_range(0, 9));
            if (k < 7)       a = {53'd0, 8'($urandom), 3'd0};
            else if (k == 7) a = {53'd0, 8'($urandom), 3'($urandom_range(1, 7))};
            else             a = {$urandom, $urandom} | (64'd1 << $urandom_range(11, 63));
            if ($urandom_range(0, 3) == 0) a = {$urandom, $urandom};
            k = int'($urandom_range(0, 19));
            step("rnd", ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom), (k < 7) || (k == 19), (k >= 7 && k < 14) || (k == 19),
                 a, {$urandom, $urandom}, 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
